// File: rtl/debug_pkg.sv
// Shared state encoding, control-word bit positions and defaults for debug_mem_seq.
package debug_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HALT   = 3'd1,
      ST_ACCESS = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DONE   = 3'd4
   } dbg_state_e;

   localparam int CTRL_GO     = 0;
   localparam int CTRL_WRITE  = 1;
   localparam int CTRL_EXT    = 2;
   localparam int CTRL_RESUME = 3;
   localparam int CTRL_BE_LSB = 4;
   localparam int CTRL_BE_MSB = 7;

   localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/dbg_timeout_cnt.sv
// Down-counting watchdog: load arms it, expired flags CYCLES enabled cycles since the load.
module dbg_timeout_cnt #(
   parameter int CYCLES = 255
) (
   input  logic CLK,
   input  logic RST,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (enable && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/debug_mem_seq.sv
// Debug memory sequencer: halts the core, performs one instr/ext access, reports the result.
// Optional abort on a stuck halt/ack is enabled with `define DBG_TIMEOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no command in flight, waiting for cmd_valid with go=1
// ST_HALT   | halt_req asserted, waiting for halted
// ST_ACCESS | one-cycle mem_re or mem_we strobe
// ST_WAIT   | bus held stable, waiting for mem_ack
// ST_DONE   | one-cycle rsp_valid, then back to idle
module debug_mem_seq
   import debug_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        cmd_valid,
   input  logic [31:0] cmd_ctrl,
   input  logic [31:0] cmd_iaddr,
   input  logic [31:0] cmd_eaddr,
   input  logic [31:0] cmd_wdata,
   output logic        busy,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        halt_req,
   input  logic        halted,
   output logic        mem_sel,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        mem_re,
   output logic        mem_we,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   dbg_state_e  state_q;
   logic        write_q;
   logic        ext_q;
   logic        resume_q;
   logic [3:0]  be_q;
   logic [31:2] addr_q;
   logic [31:0] wdata_q;

   logic        busy_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic        halt_req_q;
   logic        mem_sel_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic [3:0]  mem_be_q;
   logic        mem_re_q;
   logic        mem_we_q;

   logic        accept;
   assign accept = (state_q == ST_IDLE) && cmd_valid && cmd_ctrl[CTRL_GO];

   // Upper control bits and the byte offset of the address are don't-care.
   logic unused_inputs;
   assign unused_inputs = ^{cmd_ctrl[31:8], cmd_iaddr[1:0], cmd_eaddr[1:0]};

`ifdef DBG_TIMEOUT_EN
   logic rsp_err_q;
   logic tmo_load;
   logic tmo_enable;
   logic tmo_expired;

   assign tmo_load   = accept || (state_q == ST_ACCESS);
   assign tmo_enable = (state_q == ST_HALT) || (state_q == ST_WAIT);

   dbg_timeout_cnt #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .CLK     (CLK),
      .RST     (RST),
      .load    (tmo_load),
      .enable  (tmo_enable),
      .expired (tmo_expired)
   );

   assign rsp_err = rsp_err_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         write_q     <= 1'b0;
         ext_q       <= 1'b0;
         resume_q    <= 1'b0;
         be_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         halt_req_q  <= 1'b0;
         mem_sel_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
`ifdef DBG_TIMEOUT_EN
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  write_q    <= cmd_ctrl[CTRL_WRITE];
                  ext_q      <= cmd_ctrl[CTRL_EXT];
                  resume_q   <= cmd_ctrl[CTRL_RESUME];
                  be_q       <= cmd_ctrl[CTRL_BE_MSB:CTRL_BE_LSB];
                  addr_q     <= cmd_ctrl[CTRL_EXT] ? cmd_eaddr[31:2] : cmd_iaddr[31:2];
                  wdata_q    <= cmd_wdata;
                  busy_q     <= 1'b1;
                  halt_req_q <= 1'b1;
                  state_q    <= ST_HALT;
`ifdef DBG_TIMEOUT_EN
                  rsp_err_q  <= 1'b0;
`endif
               end
            end

            ST_HALT: begin
               if (halted) begin
                  mem_sel_q   <= ext_q;
                  mem_addr_q  <= {addr_q, 2'b00};
                  mem_wdata_q <= wdata_q;
                  mem_be_q    <= be_q;
                  mem_we_q    <= write_q;
                  mem_re_q    <= !write_q;
                  state_q     <= ST_ACCESS;
`ifdef DBG_TIMEOUT_EN
               end else if (tmo_expired) begin
                  // The core never stopped, so release the request rather than leave it pending.
                  halt_req_q  <= 1'b0;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= '0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
`endif
               end
            end

            ST_ACCESS: begin
               state_q <= ST_WAIT;
            end

            ST_WAIT: begin
               if (mem_ack) begin
                  if (!write_q) begin
                     rsp_rdata_q <= mem_rdata;
                  end
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
`ifdef DBG_TIMEOUT_EN
               end else if (tmo_expired) begin
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= '0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
`endif
               end
            end

            ST_DONE: begin
               busy_q <= 1'b0;
               if (resume_q) begin
                  halt_req_q <= 1'b0;
               end
               state_q <= ST_IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign halt_req  = halt_req_q;
   assign mem_sel   = mem_sel_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign mem_re    = mem_re_q;
   assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_debug_mem_seq.sv
// Scoreboard bench for debug_mem_seq: random commands against a transaction-level model.
`timescale 1ns/1ps
module tb_debug_mem_seq;

   localparam int TMO = 8;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [31:0] cmd_ctrl = '0;
   logic [31:0] cmd_iaddr = '0;
   logic [31:0] cmd_eaddr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        busy;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        halt_req;
   logic        halted = 1'b0;
   logic        mem_sel;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_re;
   logic        mem_we;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   debug_mem_seq #(.TIMEOUT_CYCLES(TMO)) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ctrl(cmd_ctrl), .cmd_iaddr(cmd_iaddr),
      .cmd_eaddr(cmd_eaddr), .cmd_wdata(cmd_wdata),
      .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .halt_req(halt_req), .halted(halted),
      .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_re(mem_re), .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 CLK = ~CLK;

   int     checks = 0;
   int     failures = 0;
   longint cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      bit          we;
      bit          sel;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } acc_t;

   typedef struct {
      logic [31:0] rdata;
      bit          err;
      longint      issue;
      int          lat;
   } rsp_t;

   acc_t acc_q[$];
   rsp_t rsp_q[$];

   logic [31:0] last_rdata = '0;
   bit          exp_halt = 1'b0;
   bit          fixed_en = 1'b0;
   logic [31:0] fixed_rd = '0;
   int          ack_delay = 0;
   bit          ack_never = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory contents as seen by the responder: a fixed scramble of select and address.
   function automatic logic [31:0] rd_fn(input logic sel, input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ (sel ? 32'h5A5A_C3C3 : 32'h0F0F_1234);
   endfunction

   // Memory responder: acks after ack_delay WAIT cycles, and injects stray acks when idle.
   int          ack_cnt = 0;
   logic [31:0] wait_addr = '0;
   always @(negedge CLK) begin
      mem_ack = 1'b0;
      if (RST) begin
         ack_cnt = 0;
      end else if (ack_cnt > 0) begin
         if (ack_never && (rsp_valid || !busy)) begin
            ack_cnt = 0;
         end else begin
            chk("wait_no_strobe", {30'b0, mem_re, mem_we}, 32'h0);
            chk("wait_addr_stable", mem_addr, wait_addr);
            if (!ack_never) begin
               ack_cnt--;
               if (ack_cnt == 0) begin
                  mem_ack   = 1'b1;
                  mem_rdata = fixed_en ? fixed_rd : rd_fn(mem_sel, mem_addr);
               end
            end
         end
      end else if (mem_re || mem_we) begin
         ack_cnt   = ack_delay + 1;
         wait_addr = mem_addr;
      end else if ($urandom_range(0, 3) == 0) begin
         mem_ack   = 1'b1;
         mem_rdata = $urandom;
      end
   end

   bit prev_acc = 1'b0;
   always @(negedge CLK) begin
      if (mem_re || mem_we) begin
         acc_t ea;
         chk("acc_one_cycle", {31'b0, prev_acc}, 32'h0);
         chk("acc_re_we_excl", {31'b0, mem_re & mem_we}, 32'h0);
         if (acc_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL acc_unexpected: got access addr=0x%08h expected none", mem_addr);
         end else begin
            ea = acc_q.pop_front();
            chk("acc_we", {31'b0, mem_we}, {31'b0, ea.we});
            chk("acc_sel", {31'b0, mem_sel}, {31'b0, ea.sel});
            chk("acc_addr", mem_addr, ea.addr);
            chk("acc_be", {28'b0, mem_be}, {28'b0, ea.be});
            if (ea.we) chk("acc_wdata", mem_wdata, ea.wdata);
         end
      end
      prev_acc = mem_re || mem_we;
   end

   bit prev_rv = 1'b0;
   always @(negedge CLK) begin
      if (rsp_valid) begin
         rsp_t er;
         chk("rsp_one_cycle", {31'b0, prev_rv}, 32'h0);
         if (rsp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got rsp rdata=0x%08h expected none", rsp_rdata);
         end else begin
            er = rsp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, er.rdata);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, er.err});
            chk("rsp_latency", 32'(cyc - er.issue), 32'(er.lat));
         end
      end
      prev_rv = rsp_valid;
   end

   task automatic chk_reset_vals();
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
      chk("rst_halt_req", {31'b0, halt_req}, 32'h0);
      chk("rst_mem_re", {31'b0, mem_re}, 32'h0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
      chk("rst_mem_sel", {31'b0, mem_sel}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
   endtask

   // h: cycles halted stays low after HALT entry (-1 never); a: WAIT cycles before ack (-1 never).
   task automatic issue(input logic [31:0] ctrl, input logic [31:0] ia, input logic [31:0] ea,
                        input logic [31:0] wd, input int h, input int a);
      bit          wr  = ctrl[1];
      bit          ext = ctrl[2];
      bit          res = ctrl[3];
      logic [31:0] ad;
      acc_t        ac;
      rsp_t        rs;
      ad = ext ? ea : ia;
      ad[1:0] = 2'b00;
      @(negedge CLK);
      halted    = (h == 0);
      ack_delay = (a < 0) ? 0 : a;
      ack_never = (a < 0);
      cmd_ctrl  = ctrl;
      cmd_iaddr = ia;
      cmd_eaddr = ea;
      cmd_wdata = wd;
      cmd_valid = 1'b1;
      rs.issue  = cyc;
      rs.err    = 1'b0;
      if (h >= 0) begin
         ac.we = wr; ac.sel = ext; ac.addr = ad; ac.be = ctrl[7:4]; ac.wdata = wd;
         acc_q.push_back(ac);
      end
      if (h < 0) begin
         rs.rdata = '0; rs.err = 1'b1; rs.lat = 1 + TMO; exp_halt = 1'b0;
      end else if (a < 0) begin
         rs.rdata = '0; rs.err = 1'b1; rs.lat = 3 + h + TMO; exp_halt = !res;
      end else begin
         rs.rdata = wr ? last_rdata : (fixed_en ? fixed_rd : rd_fn(ext, ad));
         rs.lat   = 4 + h + a;
         exp_halt = !res;
      end
      last_rdata = rs.rdata;
      rsp_q.push_back(rs);
      @(negedge CLK);
      cmd_valid = 1'b0;
      chk("busy_after_accept", {31'b0, busy}, 32'h1);
      chk("halt_req_in_halt", {31'b0, halt_req}, 32'h1);
      chk("err_cleared_on_accept", {31'b0, rsp_err}, 32'h0);
      if (h > 0) begin
         cmd_ctrl  = $urandom | 32'h1;
         cmd_iaddr = $urandom;
         cmd_eaddr = $urandom;
         cmd_wdata = $urandom;
         cmd_valid = 1'b1;
      end
      for (int i = 0; i < h; i++) begin
         chk("no_access_before_halted", {30'b0, mem_re, mem_we}, 32'h0);
         @(negedge CLK);
         cmd_valid = 1'b0;
      end
      if (h >= 0) halted = 1'b1;
   endtask

   task automatic finish_cmd();
      int n = 0;
      while (busy && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      if (busy) begin
         checks++;
         failures++;
         $display("FAIL done_wait: busy still 1 after %0d cycles, expected 0", n);
      end
      chk("halt_req_after", {31'b0, halt_req}, {31'b0, exp_halt});
      chk("rsp_rdata_hold", rsp_rdata, last_rdata);
      chk("rsp_all_seen", 32'(rsp_q.size()), 32'h0);
      chk("acc_all_seen", 32'(acc_q.size()), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      chk_reset_vals();
      RST = 1'b0;

      // Instruction read, halted already high: minimum latency.
      fixed_en = 1'b1;
      fixed_rd = 32'h1234_5678;
      issue(32'h0000_00F1, 32'h0000_0106, 32'hDEAD_BEEF, 32'h0, 0, 0);
      finish_cmd();
      fixed_en = 1'b0;

      // External write with resume.
      issue(32'h0000_003F, 32'h0000_0040, 32'h8000_0000, 32'hCAFE_F00D, 0, 0);
      finish_cmd();

      // go=0 is ignored.
      @(negedge CLK);
      cmd_ctrl  = 32'h0000_00FE;
      cmd_valid = 1'b1;
      @(negedge CLK);
      cmd_valid = 1'b0;
      chk("go0_ignored", {31'b0, busy}, 32'h0);

      // Slow halt with a second command issued during the wait.
      issue(32'h0000_00F5, 32'h0000_1000, 32'h4000_0013, 32'h0, 10, 2);
      finish_cmd();

      for (int k = 0; k < 25; k++) begin
         logic [31:0] c;
         int          h;
         int          a;
         c    = $urandom;
         c[0] = 1'b1;
         h    = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6);
         a    = $urandom_range(0, 4);
         issue(c, $urandom, $urandom, $urandom, h, a);
         finish_cmd();
      end

`ifdef DBG_TIMEOUT_EN
      // Ack never arrives: WAIT timeout.
      issue(32'h0000_00F1, 32'h0000_0200, 32'h0, 32'h0, 0, -1);
      finish_cmd();
      chk("err_held_in_idle", {31'b0, rsp_err}, 32'h1);
      // Core never halts: HALT timeout drops halt_req.
      issue(32'h0000_00F3, 32'h0000_0300, 32'h0, 32'h1111_2222, -1, 0);
      finish_cmd();
      issue(32'h0000_00F1, 32'h0000_0404, 32'h0, 32'h0, 1, 1);
      finish_cmd();
`endif

      // Reset pulsed while in WAIT.
      issue(32'h0000_00F1, 32'h0000_0500, 32'h0, 32'h0, 0, -1);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      #1;
      chk_reset_vals();
      rsp_q.delete();
      acc_q.delete();
      last_rdata = '0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      ack_never = 1'b0;
      issue(32'h0000_00F5, 32'h0000_0000, 32'h2000_0104, 32'h0, 1, 1);
      finish_cmd();

      repeat (3) @(negedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/debug_mem_seq.md
DEBUG_MEM_SEQ -- requirements
Module: debug_mem_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max cycles waited for halted or mem_ack before abort.
REQ-002 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  one-cycle write strobe from the debug Avalon slave register file.
REQ-005 SHALL have port cmd_ctrl  input  32  control word: [0] go, [1] write(1)/read(0), [2] target ext(1)/instr(0), [3] resume after done, [7:4] byte enables.
REQ-006 SHALL have ports cmd_iaddr, cmd_eaddr, cmd_wdata  input  32 each  instruction address, external address, write data.
REQ-007 SHALL have port busy  output  1  command in progress.
REQ-008 SHALL have ports rsp_valid  output  1  one-cycle completion pulse; rsp_rdata  output  32  read result; rsp_err  output  1  abort flag.
REQ-009 SHALL have ports halt_req  output  1  core halt request (doubles as the debug flag); halted  input  1  core halt acknowledge.
REQ-010 SHALL have ports mem_sel  output  1  (0 instr, 1 ext); mem_addr  output  32; mem_wdata  output  32; mem_be  output  4; mem_re  output  1; mem_we  output  1.
REQ-011 SHALL have ports mem_ack  input  1  access complete; mem_rdata  input  32  read data, valid with mem_ack.

Function
REQ-012 SHALL implement FSM states IDLE, HALT, ACCESS, WAIT, DONE, with all outputs registered.
REQ-013 IDLE -> HALT when cmd_valid=1 and cmd_ctrl[0]=1; SHALL latch ctrl, selected address and wdata in that cycle; busy=1 from next cycle.
REQ-014 SHALL ignore cmd_valid while busy=1, with no queueing and no change to latched command; SHALL ignore cmd_valid with go=0.
REQ-015 HALT: halt_req=1; HALT -> ACCESS on the first cycle halted=1, including halted already high on entry.
REQ-016 ACCESS: SHALL assert exactly one of mem_re/mem_we for one cycle, with mem_addr = latched address with bits [1:0] forced 0 and mem_be = ctrl[7:4]; next state WAIT.
REQ-017 WAIT: SHALL hold mem_addr/mem_sel/mem_wdata/mem_be stable with mem_re=mem_we=0; WAIT -> DONE on mem_ack=1, capturing mem_rdata on reads.
REQ-018 DONE: rsp_valid=1 for one cycle, then IDLE; busy=0 in IDLE; rsp_rdata holds until the next DONE; writes leave rsp_rdata unchanged.
REQ-019 halt_req SHALL deassert on DONE->IDLE if latched resume=1, else stay 1 until a later command with resume=1 completes.
REQ-020 mem_ack while not in WAIT SHALL be ignored.
REQ-021 rsp_err SHALL clear when a new command is accepted.
REQ-022 Minimum latency, cmd_valid to rsp_valid, SHALL be 4 cycles: halted=1 and mem_ack in the first WAIT cycle.

Reset
REQ-023 RST=1 SHALL force IDLE immediately, including mid-operation; busy, rsp_valid, rsp_err, halt_req, mem_re, mem_we and mem_sel become 0, and rsp_rdata, mem_addr, mem_wdata and mem_be become 0.
REQ-024 The first command after reset release SHALL be accepted normally.

Configuration
REQ-025 With macro DBG_TIMEOUT_EN defined, a counter SHALL run in HALT and WAIT, reset on each state entry; reaching TIMEOUT_CYCLES SHALL go to DONE with rsp_err=1 and rsp_rdata=0, and on a HALT timeout halt_req SHALL drop.
REQ-026 Without DBG_TIMEOUT_EN, HALT and WAIT SHALL wait indefinitely, rsp_err SHALL be constant 0 and no counter logic SHALL exist.

Structure
REQ-027 The shared package debug_pkg SHALL hold the FSM state enum, cmd_ctrl bit-index constants and the default TIMEOUT_CYCLES.
REQ-028 The timeout counter SHALL be sub-module dbg_timeout_cnt (load, enable, expired), instantiated only under DBG_TIMEOUT_EN.

Verification
REQ-029 Read instr: cmd_ctrl=0x0000_00F1, iaddr=0x0000_0106, halted=1, mem_ack with rdata 0x1234_5678 -> mem_addr=0x104, mem_re one cycle, rsp_rdata=0x1234_5678, rsp_valid 4 cycles after cmd_valid, halt_req stays 1.
REQ-030 Write ext with resume: cmd_ctrl=0x0000_003F, eaddr=0x8000_0000, wdata=0xCAFE_F00D -> mem_sel=1, mem_we one cycle, mem_be=0x3, halt_req=0 after DONE.
REQ-031 Halt delay: halted held low 10 cycles -> no mem_re/mem_we until halted=1; second cmd_valid during the wait is ignored.
REQ-032 DBG_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ack never asserted -> rsp_valid=1 with rsp_err=1 and rsp_rdata=0; next command clears rsp_err.
REQ-033 RST pulsed during WAIT -> all outputs take reset values at once; a subsequent read completes correctly.
